// File: rtl/ext_bus_arbiter.sv
// rtl/ext_bus_arbiter.sv - two-port external memory bus arbiter and access sequencer
module ext_bus_arbiter #(
    parameter int WAIT_CYC = 0,
    parameter bit CPU_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [1:0]  sel,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic [1:0]  ack,
    output logic [1:0]  err,
    output logic [7:0]  rdata,
    output logic [15:0] addr_bus,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        read_en,
    output logic        write_en,
    output logic        memory_select,
    output logic        psen
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYC);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic        gnt, gnt_nxt, last_gnt;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic        lat_we, lat_sel;
    logic        last_access;

    // On a tie the fixed-priority mode always picks the CPU; otherwise the port served last loses.
    always_comb begin
        gnt_nxt = req[1];
        if (req == 2'b11) begin
            gnt_nxt = CPU_PRIO ? 1'b0 : ~last_gnt;
        end
    end

    assign last_access = (state == ACCESS) && (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (last_access) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 3'd0;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            lat_addr  <= 16'h0000;
            lat_wdata <= 8'h00;
            lat_we    <= 1'b0;
            lat_sel   <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            if (state == IDLE && |req) begin
                gnt       <= gnt_nxt;
                last_gnt  <= gnt_nxt;
                lat_addr  <= gnt_nxt ? addr1 : addr0;
                lat_wdata <= gnt_nxt ? wdata1 : wdata0;
                lat_we    <= we[gnt_nxt];
                lat_sel   <= sel[gnt_nxt];
            end
            cnt <= (state == ACCESS) ? cnt + 3'd1 : 3'd0;
            if (last_access && !lat_we) begin
                rdata <= data_in;
            end
        end
    end

    // Address, select and write data follow the latched request so they hold through DONE and IDLE.
    always_comb begin
        ack           = 2'b00;
        err           = 2'b00;
        data_oe       = 1'b0;
        read_en       = 1'b0;
        write_en      = 1'b0;
        psen          = 1'b1;
        addr_bus      = lat_addr;
        data_out      = lat_wdata;
        memory_select = lat_sel;
        case (state)
            SETUP: data_oe = lat_we;
            ACCESS: begin
                if (!lat_we) begin
                    read_en = 1'b1;
                    psen    = lat_sel;
                end else if (lat_sel) begin
                    write_en = 1'b1;
                    data_oe  = 1'b1;
                end
            end
            DONE: begin
                ack = gnt ? 2'b10 : 2'b01;
                if (lat_we && !lat_sel) begin
                    err = gnt ? 2'b10 : 2'b01;
                end
            end
            default: ;
        endcase
    end
endmodule
